// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, the FIFO entry layout and a small decode helper.
package regfile_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // One buffered register write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Which FIFO head owns the write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_MEM  = 2'd2
  } grant_e;

  // One-hot decode of a destination register number.
  function automatic logic [REG_NUM-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [REG_NUM-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO of {rd, data} write-back entries. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
// Per-entry valid bits and rd fields are exported for the pending decode.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wb_entry_t                           push_entry,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output wb_entry_t                           head,
  output logic [DEPTH-1:0]                    entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_rd
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        do_push;
  logic        do_pop;
  wb_entry_t   mem_q [DEPTH];

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem_q[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful while the slot is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [AW-1:0] off;
    entry_valid = '0;
    entry_rd    = '0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = AW'(i) - rd_ptr[AW-1:0];
      entry_valid[i] = ({1'b0, off} < count);
      entry_rd[i]    = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port. Buffers
// ALU and memory/multiply writes in per-requester FIFOs, grants one head
// per cycle (ALU first, memory forced after STARVE_LIMIT denials) and
// exports a mask of registers with writes still buffered.
//
// Handshake: a requester's entry is taken at a rising clk edge where its
// valid and ready are both 1; ready depends only on FIFO fullness and is
// held low during reset and until the first edge after release.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] dstreg_num,
  output logic [XLEN-1:0]       dstreg_data,
  output logic [REG_NUM-1:0]    pending_mask
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic                             rdy_en;
  logic                             alu_push, alu_pop, alu_full, alu_empty;
  logic                             mem_push, mem_pop, mem_full, mem_empty;
  wb_entry_t                        alu_in, mem_in, alu_head, mem_head;
  logic [DEPTH-1:0]                 alu_ev, mem_ev;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] alu_erd, mem_erd;
  logic [SW-1:0]                    starve_cnt, starve_d;
  grant_e                           grant;

  assign alu_ready = rdy_en && !alu_full;
  assign mem_ready = rdy_en && !mem_full;

  // Writes to x0 are accepted but never buffered.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign alu_in   = '{rd: alu_rd, data: alu_data};
  assign mem_in   = '{rd: mem_rd, data: mem_data};
  assign alu_pop  = (grant == GRANT_ALU);
  assign mem_pop  = (grant == GRANT_MEM);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push(alu_push), .push_entry(alu_in), .pop(alu_pop),
    .full(alu_full), .empty(alu_empty), .head(alu_head),
    .entry_valid(alu_ev), .entry_rd(alu_erd)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .rst(rst), .push(mem_push), .push_entry(mem_in), .pop(mem_pop),
    .full(mem_full), .empty(mem_empty), .head(mem_head),
    .entry_valid(mem_ev), .entry_rd(mem_erd)
  );

  // Ready enable: low in reset, rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  // Grant: ALU wins ties unless memory has been denied STARVE_LIMIT times.
  always_comb begin
    grant = GRANT_NONE;
    if (!mem_empty && (alu_empty || starve_cnt == LIMIT)) grant = GRANT_MEM;
    else if (!alu_empty)                                  grant = GRANT_ALU;
  end

  // Drive the register file write port from the granted head.
  always_comb begin
    reg_we      = DISABLE;
    dstreg_num  = '0;
    dstreg_data = '0;
    if (grant == GRANT_ALU) begin
      reg_we      = ENABLE;
      dstreg_num  = alu_head.rd;
      dstreg_data = alu_head.data;
    end else if (grant == GRANT_MEM) begin
      reg_we      = ENABLE;
      dstreg_num  = mem_head.rd;
      dstreg_data = mem_head.data;
    end
  end

  // Starvation counter next value: counts ALU wins over a waiting memory head.
  always_comb begin
    starve_d = starve_cnt;
    if (mem_empty || grant == GRANT_MEM)
      starve_d = '0;
    else if (grant == GRANT_ALU && starve_cnt != LIMIT)
      starve_d = starve_cnt + SW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt <= '0;
    else      starve_cnt <= starve_d;
  end

  // Pending mask: OR of the one-hot rd of every live entry in both FIFOs.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ev[i]) pending_mask = pending_mask | rd_onehot(alu_erd[i]);
      if (mem_ev[i]) pending_mask = pending_mask | rd_onehot(mem_erd[i]);
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1 time unit after each rising edge; outputs are read then.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        reg_we;
  logic [4:0]  dstreg_num;
  logic [31:0] dstreg_data;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .reg_we(reg_we), .dstreg_num(dstreg_num), .dstreg_data(dstreg_data),
    .pending_mask(pending_mask)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    #2;
    checks++;
    if ({reg_we, dstreg_num, dstreg_data} !== 38'd0) begin
      errors++; $display("FAIL reset_port: got we=%b num=%0d data=%h, want 0", reg_we, dstreg_num, dstreg_data);
    end
    checks++;
    if (pending_mask !== 32'd0) begin
      errors++; $display("FAIL reset_pending: got %h want 0", pending_mask);
    end
    checks++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {alu_ready, mem_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if ({alu_ready, mem_ready} !== 2'b11) begin
      errors++; $display("FAIL release_ready: got %b want 11", {alu_ready, mem_ready});
    end
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({reg_we, dstreg_num, dstreg_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_write: got we=%b num=%0d data=%h want 1/5/deadbeef", reg_we, dstreg_num, dstreg_data);
    end
    checks++;
    if (pending_mask !== 32'h0000_0020) begin
      errors++; $display("FAIL single_pending: got %h want 00000020", pending_mask);
    end
    tick();
    checks++;
    if (reg_we !== 1'b0 || pending_mask !== 32'd0) begin
      errors++; $display("FAIL single_after: got we=%b mask=%h want 0/0", reg_we, pending_mask);
    end
  endtask

  task automatic test_x0_drop();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
    tick();
    mem_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (reg_we !== 1'b0 || pending_mask !== 32'd0) begin
        errors++; $display("FAIL x0_drop cycle %0d: got we=%b mask=%h want 0/0", k, reg_we, pending_mask);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 32'hA000_0000 + 32'(k);
      tick();
      checks++;
      if ({reg_we, dstreg_num, dstreg_data} !== {1'b1, 5'(k), 32'hA000_0000 + 32'(k)}) begin
        errors++; $display("FAIL b2b_write %0d: got we=%b num=%0d data=%h", k, reg_we, dstreg_num, dstreg_data);
      end
      checks++;
      if (pending_mask !== (32'd1 << k)) begin
        errors++; $display("FAIL b2b_pending %0d: got %h want %h", k, pending_mask, 32'd1 << k);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [4:0] obs_q[$];
    int idx;
    bit seen_full;
    bit acc;
    idx = 0;
    seen_full = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_0AAA;
    mem_valid = 1'b1; mem_rd = 5'd1;  mem_data = 32'h0000_0101;
    for (int cyc = 0; cyc < 46; cyc++) begin
      if (cyc == 40) alu_valid = 1'b0;
      if (reg_we && dstreg_num != 5'd10) obs_q.push_back(dstreg_num);
      if (!seen_full && mem_valid && !mem_ready) begin
        seen_full = 1'b1;
        checks++;
        if (idx !== 2) begin
          errors++; $display("FAIL bp_full_after: mem_ready fell after %0d accepts, want 2", idx);
        end
      end
      acc = mem_valid && mem_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          mem_rd = 5'(idx + 1); mem_data = 32'h0000_0101 * 32'(idx + 1);
        end else begin
          mem_valid = 1'b0;
        end
      end
    end
    checks++;
    if (!seen_full) begin
      errors++; $display("FAIL bp_never_full: mem_ready never fell, want fall after 2 accepts");
    end
    checks++;
    if (obs_q.size() !== 3) begin
      errors++; $display("FAIL bp_count: got %0d memory writes want 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_q[k] !== 5'(k + 1)) begin
          errors++; $display("FAIL bp_order %0d: got rd %0d want %0d", k, obs_q[k], k + 1);
        end
      end
    end
    drain();
  endtask

  task automatic test_starvation();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_000A;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h0000_0014;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (reg_we !== 1'b1 || dstreg_num !== ((k % 5 == 4) ? 5'd20 : 5'd10)) begin
        errors++; $display("FAIL starve_grant %0d: got we=%b num=%0d want 1/%0d", k, reg_we, dstreg_num, (k % 5 == 4) ? 20 : 10);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full_fifo();
    bit found;
    found = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_000A;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h0000_0014;
    tick();
    for (int k = 0; k < 12 && !found; k++) begin
      if (reg_we && dstreg_num == 5'd20) found = 1'b1;
      tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL full_timeout: no memory grant within 12 cycles");
    end else begin
      checks++;
      if (alu_ready !== 1'b0 || reg_we !== 1'b1 || dstreg_num !== 5'd10) begin
        errors++; $display("FAIL full_pop_cycle: got ready=%b we=%b num=%0d want 0/1/10", alu_ready, reg_we, dstreg_num);
      end
      tick();
      checks++;
      if (alu_ready !== 1'b1) begin
        errors++; $display("FAIL full_next_cycle: got ready=%b want 1", alu_ready);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_000A;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h0000_0015;
    tick();
    tick();
    checks++;
    if (pending_mask !== 32'h0020_0400) begin
      errors++; $display("FAIL mid_pending_before: got %h want 00200400", pending_mask);
    end
    #2;
    rst = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    checks++;
    if ({reg_we, dstreg_num, pending_mask, alu_ready, mem_ready} !== 40'd0) begin
      errors++; $display("FAIL mid_reset_now: got we=%b num=%0d mask=%h rdy=%b%b want all 0", reg_we, dstreg_num, pending_mask, alu_ready, mem_ready);
    end
    tick();
    checks++;
    if ({reg_we, pending_mask, alu_ready, mem_ready} !== 35'd0) begin
      errors++; $display("FAIL mid_reset_held: got we=%b mask=%h rdy=%b%b want all 0", reg_we, pending_mask, alu_ready, mem_ready);
    end
    #2;
    rst = 1'b1;
    tick();
    checks++;
    if ({alu_ready, mem_ready} !== 2'b11) begin
      errors++; $display("FAIL mid_release_ready: got %b want 11", {alu_ready, mem_ready});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (reg_we !== 1'b0 || pending_mask !== 32'd0) begin
        errors++; $display("FAIL mid_stale %0d: got we=%b mask=%h want 0/0", k, reg_we, pending_mask);
      end
      tick();
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_alu();
    test_x0_drop();
    test_back_to_back();
    test_backpressure();
    test_starvation();
    test_full_fifo();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
